// File: rtl/flit_injector_if.sv
// flit_injector_if: control inputs and flit/status outputs of flit_injector.
//   start, abort, mode         : run control (driven by master)
//   input1, input2             : low/high halves of the 2N-bit flit word
//   valid, busy, done          : flit strobe, run-active flag, completion pulse
//   flit_cnt, pkt_cnt          : flits in current packet, packets done in run
// master = the controlling side, slave = the injector.
interface flit_injector_if #(parameter int N = 27);
   logic         start;
   logic         abort;
   logic         mode;
   logic [N-1:0] input1;
   logic [N-1:0] input2;
   logic         valid;
   logic         busy;
   logic         done;
   logic [15:0]  flit_cnt;
   logic [15:0]  pkt_cnt;

   modport master (
      output start, abort, mode,
      input  input1, input2, valid, busy, done, flit_cnt, pkt_cnt
   );

   modport slave (
      input  start, abort, mode,
      output input1, input2, valid, busy, done, flit_cnt, pkt_cnt
   );
endinterface

// File: rtl/flit_injector.sv
// flit_injector: emits NUM_PKT packets of PAYLOAD flits separated by GAP idle
// cycles. Each flit is a 2N-bit pattern word W split across the two adder
// operands; W restarts at 0 per packet and advances as a binary counter
// (mode 0) or a Johnson counter (mode 1).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : flit_injector_if.slave (start/abort/mode in; operands, valid,
//          busy, done, flit_cnt, pkt_cnt out -- all registered)
module flit_injector #(
   parameter int N       = 27,
   parameter int PAYLOAD = 20,
   parameter int GAP     = 7,
   parameter int NUM_PKT = 10
) (
   input logic             clk,
   input logic             rst,
   flit_injector_if.slave  bus
);

   localparam int          WW        = 2 * N;
   localparam logic [WW-1:0] W_ONE   = WW'(1);
   localparam logic [15:0] PAYLOAD16 = 16'(PAYLOAD);
   localparam logic [15:0] NUM_PKT16 = 16'(NUM_PKT);
   // Only meaningful when GAP > 0; the GAP state is never entered otherwise.
   localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

   state_t         state, state_d;
   logic [WW-1:0]  w, w_d;
   logic           mode_q, mode_d;
   logic [15:0]    flit_cnt, flit_d;
   logic [15:0]    pkt_cnt, pkt_d;
   logic [15:0]    gap_cnt, gap_d;
   logic           valid, valid_d;
   logic           busy, busy_d;
   logic           done, done_d;
   logic           last_pkt;

   function automatic logic [WW-1:0] next_w(input logic [WW-1:0] cur, input logic m);
      if (m) next_w = {cur[WW-2:0], ~cur[WW-1]};
      else   next_w = cur + W_ONE;
   endfunction

   // 17-bit compare so pkt_cnt+1 cannot wrap when NUM_PKT = 65535.
   assign last_pkt = ({1'b0, pkt_cnt} + 17'd1) >= {1'b0, NUM_PKT16};

   always_comb begin
      state_d = state;
      w_d     = w;
      mode_d  = mode_q;
      flit_d  = flit_cnt;
      pkt_d   = pkt_cnt;
      gap_d   = gap_cnt;
      valid_d = 1'b0;
      busy_d  = busy;
      done_d  = 1'b0;
      case (state)
         S_IDLE: begin
            busy_d = 1'b0;
            if (bus.start && !bus.abort) begin
               mode_d  = bus.mode;
               pkt_d   = '0;
               w_d     = next_w('0, bus.mode);
               flit_d  = 16'd1;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (bus.abort) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (flit_cnt == PAYLOAD16) begin
               if (last_pkt) begin
                  pkt_d   = NUM_PKT16;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  pkt_d = pkt_cnt + 16'd1;
                  if (GAP == 0) begin
                     // back-to-back: next packet's first flit right away
                     w_d     = next_w('0, mode_q);
                     flit_d  = 16'd1;
                     valid_d = 1'b1;
                  end else begin
                     gap_d   = '0;
                     state_d = S_GAP;
                  end
               end
            end else begin
               w_d     = next_w(w, mode_q);
               flit_d  = flit_cnt + 16'd1;
               valid_d = 1'b1;
            end
         end
         S_GAP: begin
            if (bus.abort) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (gap_cnt == GAP_LAST) begin
               w_d     = next_w('0, mode_q);
               flit_d  = 16'd1;
               valid_d = 1'b1;
               state_d = S_SEND;
            end else begin
               gap_d = gap_cnt + 16'd1;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         w        <= '0;
         mode_q   <= 1'b0;
         flit_cnt <= '0;
         pkt_cnt  <= '0;
         gap_cnt  <= '0;
         valid    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_d;
         w        <= w_d;
         mode_q   <= mode_d;
         flit_cnt <= flit_d;
         pkt_cnt  <= pkt_d;
         gap_cnt  <= gap_d;
         valid    <= valid_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

   assign bus.input1   = w[N-1:0];
   assign bus.input2   = w[WW-1:N];
   assign bus.valid    = valid;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.flit_cnt = flit_cnt;
   assign bus.pkt_cnt  = pkt_cnt;

endmodule

// File: doc/flit_injector.md
FLIT_INJECTOR -- requirements
Module: flit_injector

Interface
REQ-001 Parameter N, default 27: width of each adder operand; the internal flit word is 2N bits.
REQ-002 Parameter PAYLOAD, default 20: flits per packet, legal range 1..65535.
REQ-003 Parameter GAP, default 7: idle cycles between packets, legal range 0..65535.
REQ-004 Parameter NUM_PKT, default 10: packets per run, legal range 1..65535.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port start, input, 1 bit: launch request, sampled only in IDLE.
REQ-008 Port abort, input, 1 bit: cancels a run in progress.
REQ-009 Port mode, input, 1 bit: pattern select, sampled at launch; 0 = binary counter, 1 = Johnson (twisted-ring) counter.
REQ-010 Port input1, output, N bits: flit word bits [N-1:0], drives the adder's first operand.
REQ-011 Port input2, output, N bits: flit word bits [2N-1:N], drives the adder's second operand.
REQ-012 Port valid, output, 1 bit: high in every cycle a new flit is presented.
REQ-013 Port busy, output, 1 bit: high in the SEND and GAP states.
REQ-014 Port done, output, 1 bit: one-cycle pulse when a run completes normally.
REQ-015 Port flit_cnt, output, 16 bits: flits emitted in the current packet.
REQ-016 Port pkt_cnt, output, 16 bits: packets completed in the current run.

Function
REQ-017 States: IDLE, SEND, GAP, DONE; all outputs are registered.
REQ-018 In IDLE, start=1 with abort=0 captures mode, clears pkt_cnt, enters SEND, and emits flit 1 in the next cycle (latency 1).
REQ-019 Pattern word W is 2N bits; W restarts from 0 at each packet, and each flit emits W <= next(W).
REQ-020 In mode 0, next(W) = W+1 modulo 2^(2N); the all-ones value wraps to 0.
REQ-021 In mode 1, next(W) = {W[2N-2:0], ~W[2N-1]}.
REQ-022 In SEND, each cycle emits one flit with valid=1, and flit_cnt increments, ending at PAYLOAD on the last flit.
REQ-023 At the last flit with pkt_cnt+1 < NUM_PKT and GAP > 0: pkt_cnt increments and the block enters GAP for exactly GAP cycles.
REQ-024 At the last flit with pkt_cnt+1 < NUM_PKT and GAP = 0: the next packet's flit 1 follows in the next cycle with no valid gap.
REQ-025 At the last flit with pkt_cnt+1 = NUM_PKT: pkt_cnt becomes NUM_PKT and the block enters DONE.
REQ-026 In GAP, valid=0, input1/input2 hold the last flit value, and flit_cnt holds PAYLOAD; after GAP cycles the next packet's flit 1 is emitted.
REQ-027 DONE lasts exactly one cycle with done=1, valid=0, and busy=0, then returns to IDLE; operands and counters hold.
REQ-028 Total run length from the launch edge: NUM_PKT*PAYLOAD + (NUM_PKT-1)*GAP cycles of busy, then the done cycle; with defaults, 263 busy cycles and done in cycle 264.
REQ-029 abort=1 in SEND or GAP returns to IDLE at that edge: valid=0, done is not asserted, and operands and counters hold their values.
REQ-030 abort=1 and start=1 together in IDLE: abort wins and no run launches.
REQ-031 start while busy or in DONE is ignored, with no restart and no queuing.
REQ-032 A change in mode during a run has no effect until the next launch.

Reset
REQ-033 rst=1 at a rising edge forces IDLE in the following cycle, with input1=0, input2=0, valid=0, busy=0, done=0, flit_cnt=0, pkt_cnt=0, W=0, and captured mode=0.
REQ-034 rst has priority over start, abort, and every state, including a mid-packet SEND or GAP.

Verification
REQ-035 The bench shall cover: defaults, mode 0, start pulse -> flit 1 gives input1=0x0000001, input2=0; flit 20 gives input1=0x0000014; valid is low for 7 cycles; done is high in cycle 264 after the launch edge; pkt_cnt=10.
REQ-036 The bench shall cover: defaults, mode 1 -> flit k presents k low ones (flit 20 gives input1=0x00FFFFF, input2=0), and W restarts at each packet.
REQ-037 The bench shall cover: N=4, PAYLOAD=300, NUM_PKT=1, mode 0 -> flit 255 gives W=0xFF, flit 256 gives W=0x00; mode 1 gives flit 8 = 0xFF and flit 9 = 0xFE.
REQ-038 The bench shall cover: GAP=0, PAYLOAD=3, NUM_PKT=2 -> valid stays high for 6 consecutive cycles and flit 4 has W=1.
REQ-039 The bench shall cover: abort in GAP after packet 3 -> IDLE next cycle, no done, pkt_cnt=3; a new start then launches a fresh run with pkt_cnt cleared.
REQ-040 The bench shall cover: rst asserted at flit 10 of packet 2 -> all outputs 0 next cycle; start during rst is ignored; start after rst launches normally.
